// File: rtl/stack_pkg.sv
// stack_pkg: mode encoding and default geometry shared by param_stack and stack_ptr_ctrl.
package stack_pkg;
    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } mode_e;
    localparam int DEF_W = 8;
    localparam int DEF_H = 3;
endpackage

// File: rtl/stack_ptr_ctrl.sv
// stack_ptr_ctrl: occupancy, LIFO/FIFO addressing, effective mode and sticky error flags.
module stack_ptr_ctrl import stack_pkg::*; #(
    parameter int H = DEF_H
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic         push,
    input  logic         pop,
    input  logic         mode,
    output logic         wr_en,
    output logic [H-1:0] wr_addr,
    output logic         rd_en,
    output logic [H-1:0] rd_addr,
    output logic [H:0]   count,
    output logic         full,
    output logic         empty,
    output logic         ovf,
    output logic         udf
);
    localparam int D = 2**H;
    mode_e mode_q, mode_d, cur_mode;
    logic [H:0] count_q, count_d;
    logic [H-1:0] top, rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic ovf_q, ovf_d, udf_q, udf_d;
    assign count = count_q;
    assign empty = count_q == '0;
    assign full = count_q == (H+1)'(D);
    assign ovf = ovf_q;
    assign udf = udf_q;
    // An empty store adopts the requested mode for the same operation that loads the mode register.
    assign cur_mode = empty ? mode_e'(mode) : mode_q;
    assign top = count_q[H-1:0] - H'(1);
    assign wr_en = en & push & (~full | pop);
    assign rd_en = en & pop & ~empty;
    always_comb begin
        mode_d = (en & empty) ? mode_e'(mode) : mode_q;
        count_d = count_q + (H+1)'(wr_en & ~rd_en) - (H+1)'(rd_en & ~wr_en);
        rd_addr = cur_mode == MODE_FIFO ? rd_ptr_q : top;
        wr_addr = cur_mode == MODE_FIFO ? wr_ptr_q : (rd_en ? top : count_q[H-1:0]);
        rd_ptr_d = rd_ptr_q + H'(rd_en && cur_mode == MODE_FIFO);
        wr_ptr_d = wr_ptr_q + H'(wr_en && cur_mode == MODE_FIFO);
        ovf_d = ovf_q | (en & push & ~pop & full);
        udf_d = udf_q | (en & pop & ~push & empty);
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            mode_q   <= MODE_LIFO;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
endmodule

// File: rtl/param_stack.sv
// param_stack: LIFO/FIFO store with registered read data; define STACK_PEEK_EN to add the
// combinational peek output showing the current top/head (0 when empty).
module param_stack import stack_pkg::*; #(
    parameter int W = DEF_W,
    parameter int H = DEF_H
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic         push,
    input  logic         pop,
    input  logic         mode,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         full,
    output logic         empty,
    output logic [H:0]   count,
    output logic         ovf,
    output logic         udf
`ifdef STACK_PEEK_EN
    ,
    output logic [W-1:0] peek
`endif
);
    localparam int D = 2**H;
    logic [W-1:0] mem [D];
    logic [W-1:0] data_out_q;
    logic wr_en, rd_en;
    logic [H-1:0] wr_addr, rd_addr;
    stack_ptr_ctrl #(.H(H)) u_ctrl (
        .clk     (clk),
        .clear   (clear),
        .en      (en),
        .push    (push),
        .pop     (pop),
        .mode    (mode),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .udf     (udf)
    );
    // The read samples the old entry, so a same-cycle LIFO replace returns the prior top.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_in;
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) data_out_q <= '0;
        else if (rd_en) data_out_q <= mem[rd_addr];
    end
    assign data_out = data_out_q;
`ifdef STACK_PEEK_EN
    assign peek = empty ? '0 : mem[rd_addr];
`endif
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: scoreboard bench for param_stack (W=8, H=3); a queue model predicts
// occupancy and flags, popped values go through an expected-output queue.
module tb_param_stack;
    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       en = 1'b0, push = 1'b0, pop = 1'b0, mode = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       full, empty, ovf, udf;
    logic [3:0] count;
`ifdef STACK_PEEK_EN
    logic [7:0] peek;
`endif
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] stk[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_dout = '0;
    logic       m_mode = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    param_stack #(.W(8), .H(3)) dut (
        .clk      (clk),
        .clear    (clear),
        .en       (en),
        .push     (push),
        .pop      (pop),
        .mode     (mode),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf),
        .udf      (udf)
`ifdef STACK_PEEK_EN
        ,
        .peek     (peek)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check("count", 32'(count), 32'(stk.size()));
        check("full", 32'(full), 32'(stk.size() == 8));
        check("empty", 32'(empty), 32'(stk.size() == 0));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
`ifdef STACK_PEEK_EN
        check("peek", 32'(peek), stk.size() == 0 ? 32'd0 : 32'(m_mode ? stk[0] : stk[$]));
`endif
    endtask

    task automatic step(input logic e, input logic p, input logic q, input logic m, input logic [7:0] d);
        bit popped = 0;
        en = e; push = p; pop = q; mode = m; data_in = d;
        if (e) begin
            if (stk.size() == 0) m_mode = m;
            if (q && stk.size() > 0) begin
                popped = 1;
                m_dout = m_mode ? stk[0] : stk[$];
                exp_q.push_back(m_dout);
                if (m_mode) void'(stk.pop_front());
                else void'(stk.pop_back());
                if (p) stk.push_back(d);
            end else if (p) begin
                if (stk.size() == 8) m_ovf = 1'b1;
                else stk.push_back(d);
            end else if (q) m_udf = 1'b1;
        end
        @(posedge clk);
        #1;
        if (popped) check("dout", 32'(data_out), 32'(exp_q.pop_front()));
        else check("dout_hold", 32'(data_out), 32'(m_dout));
        check_state();
        en = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    // clear is raised between edges with a push pending, so both the immediate effect and the aborted edge are seen
    task automatic do_clear();
        en = 1'b1; push = 1'b1; pop = 1'b0; data_in = 8'hEE;
        #2 clear = 1'b1;
        stk.delete(); exp_q.delete();
        m_dout = '0; m_mode = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        check("clr_dout", 32'(data_out), 32'd0);
        check_state();
        @(posedge clk);
        #1;
        check_state();
        clear = 1'b0;
        en = 1'b0; push = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_dout", 32'(data_out), 32'd0);
        check_state();
        clear = 1'b0;
        // LIFO fill and drain
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 8'(2 << i));
        check("lifo_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 8'h00);
        check("lifo_empty", 32'(empty), 32'd1);
        // FIFO order plus pointer wrap via simultaneous push/pop
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 8'(2 << i));
        for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 8'h00);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 1, 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 8'h00);
        // overflow then replace-top while full
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 8'(8'h60 + i));
        step(1, 1, 0, 0, 8'hAA);
        step(1, 1, 1, 0, 8'h55);
        step(1, 0, 1, 0, 8'h00);
        // underflow and push+pop on empty
        do_clear();
        step(1, 0, 1, 0, 8'h00);
        step(1, 1, 1, 0, 8'h11);
        step(0, 1, 0, 0, 8'h99);
        step(1, 0, 1, 0, 8'h00);
        // mode request ignored while occupied, honoured once empty
        do_clear();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'(8'hC1 + i));
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 8'(8'hD1 + i));
        step(1, 0, 1, 1, 8'h00);
        do_clear();
        for (int i = 0; i < 100; i++)
            step(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        do_clear();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
